// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between core (C) and loader (L).
// Define DMEM_ARB_CORE_PRIO_EN to give the core fixed priority over the loader.
module dmem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [WIDTH-1:0]      c_wdata,
    input  logic [WIDTH/8-1:0]    c_be,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [WIDTH-1:0]      c_rdata,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [ADDR_WIDTH-1:0] l_addr,
    input  logic [WIDTH-1:0]      l_wdata,
    input  logic [WIDTH/8-1:0]    l_be,
    input  logic                  l_lock,
    output logic                  l_gnt,
    output logic                  l_rvalid,
    output logic [WIDTH-1:0]      l_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic [WIDTH/8-1:0]    mem_be,
    input  logic [WIDTH-1:0]      mem_rdata
);

    typedef enum logic {
        RR,
        LOCK
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_l;
    logic             last_l_nxt;
    logic             gnt_c;
    logic             gnt_l;
    logic             rr_c;
    logic             rr_l;
    logic             c_pend;
    logic             l_pend;
    logic [WIDTH-1:0] c_hold;
    logic [WIDTH-1:0] l_hold;

    // Round-robin pick: the port not served last wins a conflict.
    assign rr_c = c_req & (~l_req | last_l);
    assign rr_l = l_req & (~c_req | ~last_l);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= RR;
            last_l <= 1'b1;
            c_pend <= 1'b0;
            l_pend <= 1'b0;
            c_hold <= '0;
            l_hold <= '0;
        end else begin
            state  <= state_nxt;
            last_l <= last_l_nxt;
            c_pend <= c_gnt & ~c_we;
            l_pend <= l_gnt & ~l_we;
            if (c_pend) begin
                c_hold <= mem_rdata;
            end
            if (l_pend) begin
                l_hold <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_CORE_PRIO_EN
    always_comb begin
        state_nxt  = state;
        last_l_nxt = last_l;
        gnt_c      = c_req;
        gnt_l      = l_req & ~c_req;
        unique case (state)
            RR: begin
                if (gnt_c) begin
                    last_l_nxt = 1'b0;
                end else if (gnt_l) begin
                    last_l_nxt = 1'b1;
                end
                if (gnt_l & l_lock) begin
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                if (!(l_req & l_lock)) begin
                    state_nxt = RR;
                end
            end
            default: state_nxt = RR;
        endcase
    end
`else
    always_comb begin
        state_nxt  = state;
        last_l_nxt = last_l;
        gnt_c      = 1'b0;
        gnt_l      = 1'b0;
        unique case (state)
            LOCK: begin
                if (l_req & l_lock) begin
                    gnt_l = 1'b1;
                end else begin
                    // Burst over: this cycle falls back to normal arbitration.
                    gnt_c = rr_c;
                    gnt_l = rr_l;
                    state_nxt = RR;
                end
            end
            RR: begin
                gnt_c = rr_c;
                gnt_l = rr_l;
                if (rr_l & l_lock) begin
                    state_nxt = LOCK;
                end
            end
            default: state_nxt = RR;
        endcase
        if (gnt_c) begin
            last_l_nxt = 1'b0;
        end else if (gnt_l) begin
            last_l_nxt = 1'b1;
        end
    end
`endif

    assign c_gnt = gnt_c & ~reset;
    assign l_gnt = gnt_l & ~reset;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        unique case (1'b1)
            c_gnt: begin
                mem_en    = 1'b1;
                mem_we    = c_we;
                mem_addr  = c_addr;
                mem_wdata = c_wdata;
                mem_be    = c_be;
            end
            l_gnt: begin
                mem_en    = 1'b1;
                mem_we    = l_we;
                mem_addr  = l_addr;
                mem_wdata = l_wdata;
                mem_be    = l_be;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // Read data comes straight from the memory in the return cycle.
    assign c_rvalid = c_pend & ~reset;
    assign l_rvalid = l_pend & ~reset;

    always_comb begin
        c_rdata = c_hold;
        l_rdata = l_hold;
        if (reset) begin
            c_rdata = '0;
            l_rdata = '0;
        end else begin
            if (c_pend) begin
                c_rdata = mem_rdata;
            end
            if (l_pend) begin
                l_rdata = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a
// rule-level model with its own copy of memory contents.
module tb_dmem_arbiter;

    localparam int W  = 32;
    localparam int AW = 8;
    localparam int BW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          c_req, c_we;
    logic [AW-1:0] c_addr;
    logic [W-1:0]  c_wdata;
    logic [BW-1:0] c_be;
    logic          c_gnt, c_rvalid;
    logic [W-1:0]  c_rdata;
    logic          l_req, l_we, l_lock;
    logic [AW-1:0] l_addr;
    logic [W-1:0]  l_wdata;
    logic [BW-1:0] l_be;
    logic          l_gnt, l_rvalid;
    logic [W-1:0]  l_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [BW-1:0] mem_be;
    logic [W-1:0]  mem_rdata;

    dmem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_be(c_be), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_be(l_be), .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid),
        .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Memory array behind the arbiter.
    logic [7:0] phys [256];

    function automatic logic [31:0] phys_word(input logic [7:0] a);
        return {phys[a + 8'd3], phys[a + 8'd2], phys[a + 8'd1], phys[a]};
    endfunction

    always @(posedge clock) begin
        if (mem_en && mem_we) begin
            for (int b = 0; b < BW; b++) begin
                if (mem_be[b]) phys[mem_addr + 8'(b)] <= mem_wdata[8*b +: 8];
            end
        end
        if (mem_en && !mem_we) mem_rdata <= phys_word(mem_addr);
        else mem_rdata <= $urandom;
    end

    // Reference model state.
    logic [7:0]  ref_mem [256];
    bit          m_last_l;
    bit          m_burst;
    bit          pend_c, pend_l;
    logic [31:0] pend_c_data, pend_l_data;
    logic [31:0] hold_c, hold_l;
    bit          last_gc, last_gl;

    int n_asrt = 0;
    int n_fail = 0;

    logic          s_c_gnt, s_l_gnt, s_mem_en, s_mem_we;
    logic          s_c_rvalid, s_l_rvalid;
    logic [AW-1:0] s_mem_addr;
    logic [W-1:0]  s_c_rdata, s_l_rdata;

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
    endfunction

    task automatic ref_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] be);
        for (int b = 0; b < BW; b++) begin
            if (be[b]) ref_mem[a + 8'(b)] = d[8*b +: 8];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic predict(output bit gc, output bit gl);
        gc = 1'b0;
        gl = 1'b0;
        if (reset) return;
`ifdef DMEM_ARB_CORE_PRIO_EN
        gc = c_req;
        gl = l_req && !c_req;
`else
        if (m_burst && l_req && l_lock) gl = 1'b1;
        else if (c_req && l_req) begin
            gc = m_last_l;
            gl = !m_last_l;
        end else begin
            gc = c_req;
            gl = l_req;
        end
`endif
    endtask

    task automatic check_all(input bit gc, input bit gl);
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [W-1:0]  e_wd, e_crd, e_lrd;
        logic [BW-1:0] e_be;
        e_we = 1'b0; e_addr = '0; e_wd = '0; e_be = '0;
        if (gc) begin
            e_we = c_we; e_addr = c_addr; e_wd = c_wdata; e_be = c_be;
        end else if (gl) begin
            e_we = l_we; e_addr = l_addr; e_wd = l_wdata; e_be = l_be;
        end
        e_crd = reset ? 32'h0 : (pend_c ? pend_c_data : hold_c);
        e_lrd = reset ? 32'h0 : (pend_l ? pend_l_data : hold_l);
        s_c_gnt = c_gnt; s_l_gnt = l_gnt; s_mem_en = mem_en; s_mem_we = mem_we;
        s_mem_addr = mem_addr; s_c_rvalid = c_rvalid; s_l_rvalid = l_rvalid;
        s_c_rdata = c_rdata; s_l_rdata = l_rdata;
        chk("c_gnt", 32'(c_gnt), 32'(gc));
        chk("l_gnt", 32'(l_gnt), 32'(gl));
        chk("mem_en", 32'(mem_en), 32'(gc | gl));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wdata", mem_wdata, e_wd);
        chk("mem_be", 32'(mem_be), 32'(e_be));
        chk("c_rvalid", 32'(c_rvalid), 32'(pend_c && !reset));
        chk("l_rvalid", 32'(l_rvalid), 32'(pend_l && !reset));
        chk("c_rdata", c_rdata, e_crd);
        chk("l_rdata", l_rdata, e_lrd);
    endtask

    task automatic update(input bit gc, input bit gl);
        if (reset) begin
            m_last_l = 1'b1; m_burst = 1'b0;
            pend_c = 1'b0; pend_l = 1'b0;
            hold_c = '0; hold_l = '0;
            return;
        end
        if (pend_c) hold_c = pend_c_data;
        if (pend_l) hold_l = pend_l_data;
        pend_c = gc && !c_we;
        pend_l = gl && !l_we;
        if (pend_c) pend_c_data = ref_word(c_addr);
        if (pend_l) pend_l_data = ref_word(l_addr);
        if (gc && c_we) ref_write(c_addr, c_wdata, c_be);
        if (gl && l_we) ref_write(l_addr, l_wdata, l_be);
`ifdef DMEM_ARB_CORE_PRIO_EN
        if (!m_burst) begin
            if (gc) m_last_l = 1'b0;
            if (gl) m_last_l = 1'b1;
        end
        m_burst = m_burst ? (l_req && l_lock) : (gl && l_lock);
`else
        if (gc) m_last_l = 1'b0;
        if (gl) m_last_l = 1'b1;
        m_burst = gl && l_lock;
`endif
    endtask

    task automatic tick();
        bit gc, gl;
        @(negedge clock);
        predict(gc, gl);
        check_all(gc, gl);
        @(posedge clock);
        update(gc, gl);
        last_gc = gc;
        last_gl = gl;
        #1;
    endtask

    task automatic set_c(input logic rq, input logic we, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        c_req = rq; c_we = we; c_addr = a; c_wdata = d; c_be = be;
    endtask

    task automatic set_l(input logic rq, input logic we, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input logic lk);
        l_req = rq; l_we = we; l_addr = a; l_wdata = d; l_be = be; l_lock = lk;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            phys[i] = 8'($urandom);
            ref_mem[i] = phys[i];
        end
        {phys[8'h13], phys[8'h12], phys[8'h11], phys[8'h10]} = 32'hDEADBEEF;
        {ref_mem[8'h13], ref_mem[8'h12], ref_mem[8'h11], ref_mem[8'h10]} = 32'hDEADBEEF;
        mem_rdata = '0;
        m_last_l = 1'b1; m_burst = 1'b0;
        pend_c = 1'b0; pend_l = 1'b0;
        hold_c = '0; hold_l = '0;
        last_gc = 1'b0; last_gl = 1'b0;
        reset = 1'b1;
        set_c(0, 0, 0, 0, 0);
        set_l(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_mem_en", 32'(s_mem_en), 32'h0);

        // Single core read returns one cycle later.
        reset = 1'b0;
        set_c(1, 0, 8'h10, 0, 4'hF);
        tick();
        chk("t1_c_gnt", 32'(s_c_gnt), 32'h1);
        set_c(0, 0, 0, 0, 0);
        tick();
        chk("t1_c_rvalid", 32'(s_c_rvalid), 32'h1);
        chk("t1_c_rdata", s_c_rdata, 32'hDEADBEEF);
        chk("t1_l_rvalid", 32'(s_l_rvalid), 32'h0);

        // Conflicting reads alternate after reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_c(1, 0, 8'h00, 0, 4'hF);
        set_l(1, 0, 8'h40, 0, 4'hF, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_c_gnt", 32'(s_c_gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("t2_mem_addr", 32'(s_mem_addr), (i % 2 == 0) ? 32'h00 : 32'h40);
            if (i > 0) chk("t2_rv_alt", 32'(s_l_rvalid), (i % 2 == 1) ? 32'h0 : 32'h1);
        end
        set_c(0, 0, 0, 0, 0);
        set_l(0, 0, 0, 0, 0, 0);
        tick();
        chk("t2_last_l_rvalid", 32'(s_l_rvalid), 32'h1);

        // Core write makes the core last-served, then a locked loader burst.
        set_c(1, 1, 8'h80, 32'hCAFEF00D, 4'hF);
        tick();
        set_c(1, 0, 8'h30, 0, 4'hF);
        set_l(1, 1, 8'h20, 32'h11223344, 4'hF, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
`ifdef DMEM_ARB_CORE_PRIO_EN
            chk("t3p_c_gnt", 32'(s_c_gnt), 32'h1);
            chk("t3p_l_gnt", 32'(s_l_gnt), 32'h0);
`else
            chk("t3_l_gnt", 32'(s_l_gnt), 32'h1);
            chk("t3_c_gnt", 32'(s_c_gnt), 32'h0);
            chk("t3_mem_we", 32'(s_mem_we), 32'h1);
`endif
        end
        set_l(0, 0, 0, 0, 0, 0);
        tick();
        chk("t3_exit_c_gnt", 32'(s_c_gnt), 32'h1);
        set_c(0, 0, 0, 0, 0);
        tick();

        // Loader read cancelled by reset in the following cycle.
        set_l(1, 0, 8'h44, 0, 4'hF, 0);
        tick();
        chk("t4_l_gnt", 32'(s_l_gnt), 32'h1);
        reset = 1'b1;
        set_l(0, 0, 0, 0, 0, 0);
        tick();
        chk("t4_l_rvalid", 32'(s_l_rvalid), 32'h0);
        chk("t4_l_rdata", s_l_rdata, 32'h0);
        chk("t4_c_rdata", s_c_rdata, 32'h0);
        reset = 1'b0;
        set_c(1, 0, 8'h08, 0, 4'hF);
        set_l(1, 0, 8'h0C, 0, 4'hF, 0);
        tick();
        chk("t4_conflict_c", 32'(s_c_gnt), 32'h1);
        set_c(0, 0, 0, 0, 0);
        set_l(0, 0, 0, 0, 0, 0);
        tick();

        // Lone loader requests are granted every cycle.
        for (int i = 0; i < 5; i++) begin
            set_l(1, 0, 8'(i * 4), 0, 4'hF, 0);
            tick();
            chk("t5_l_gnt", 32'(s_l_gnt), 32'h1);
        end
        set_l(0, 0, 0, 0, 0, 0);
        tick();

        // Random traffic; requesters hold fields until granted.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            if (!(c_req && !last_gc))
                set_c($urandom_range(0, 2) != 0, 1'($urandom), 8'($urandom),
                      $urandom, 4'($urandom));
            if (!(l_req && !last_gl))
                set_l($urandom_range(0, 2) != 0, 1'($urandom), 8'($urandom),
                      $urandom, 4'($urandom), 1'b0);
            l_lock = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported, byte-addressed data memory between two requesters: port C (processor load/store path) and port L (loader/debug path that preloads or inspects data memory).
- Performs round-robin arbitration, an optional loader lock for back-to-back bursts, and read-data return with a 1-cycle latency.
- Sits between the processor's data-memory interface and the memory array.

Parameters:
- WIDTH, 32, data word width in bits.
- ADDR_WIDTH, 8, byte address width (256-byte data memory).

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- c_req  input  1  port C access request.
- c_we  input  1  port C write enable (0 = read).
- c_addr  input  ADDR_WIDTH  port C byte address.
- c_wdata  input  WIDTH  port C write data.
- c_be  input  WIDTH/8  port C byte enables.
- c_gnt  output  1  port C request accepted this cycle (combinational).
- c_rvalid  output  1  port C read data valid (registered).
- c_rdata  output  WIDTH  port C read data.
- l_req, l_we, l_addr, l_wdata, l_be  input  1/1/ADDR_WIDTH/WIDTH/WIDTH/8  port L request fields; same meaning as port C.
- l_lock  input  1  port L requests to keep the grant on the following cycle.
- l_gnt, l_rvalid, l_rdata  output  1/1/WIDTH  port L grant and read return.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write.
- mem_addr  output  ADDR_WIDTH  memory byte address.
- mem_wdata  output  WIDTH  memory write data.
- mem_be  output  WIDTH/8  memory byte enables.
- mem_rdata  input  WIDTH  memory read data, valid 1 cycle after a read strobe.

Behaviour:
- Reset values: all gnt = 0, all rvalid = 0, all rdata = 0, mem_en = 0. FSM enters RR; last_served = L, so C wins the first conflict.
- Exactly one grant per cycle at most. gnt is combinational from req and state. A transfer completes in any cycle where req & gnt.
- mem_* is a mux of the granted port's fields. mem_en = c_gnt | l_gnt. mem_we = the granted port's we. When nothing is granted, mem_* fields are 0.
- FSM state RR:
  - Only one req asserted: that port is granted.
  - Both asserted: the port not equal to last_served is granted.
  - last_served updates to the granted port on each grant.
  - No req: no grant, last_served unchanged.
  - L granted with l_lock = 1: go to LOCK.
- FSM state LOCK:
  - L has absolute priority; c_gnt = 0 even if c_req = 1.
  - Stay in LOCK while l_req & l_lock.
  - l_req = 0 or l_lock = 0: return to RR in the same cycle, and that cycle is arbitrated by RR rules.
  - On exit, last_served = L.
- Read return:
  - A granted read (we = 0) sets that port's rvalid = 1 on the next cycle, with rdata = mem_rdata captured that cycle.
  - rvalid is a 1-cycle pulse.
  - rdata holds its last value while rvalid = 0.
  - Writes never produce rvalid.
- Back-to-back reads on alternating ports return in order, one per cycle, with no bubble.
- Reset mid-operation:
  - A read granted in the cycle before reset asserts produces no rvalid.
  - Reset clears LOCK immediately.
- Requesters hold their request fields stable until gnt is seen. The arbiter does not buffer requests.
- Address and byte enables pass through unmodified. Misalignment is the memory's concern.

Optional Feature:
- Macro DMEM_ARB_CORE_PRIO_EN.
- Defined:
  - Fixed priority. Port C always wins a conflict, including in LOCK, which then only prevents last_served updates.
  - l_lock is ignored for grant purposes.
  - Keeps single-cycle processor loads stall-free.
- Undefined: round-robin and LOCK behaviour exactly as above.

Test Plan:
- Reset, then c_req = 1 read at addr 0x10 with mem_rdata = 0xDEADBEEF on the next cycle -> c_gnt = 1 in cycle 0; c_rvalid = 1 and c_rdata = 0xDEADBEEF in cycle 1; l_rvalid = 0 throughout.
- Both ports request reads for 4 cycles (C addr 0x00, L addr 0x40) -> grants C, L, C, L; rvalid pulses alternate one cycle later; mem_addr sequence 0x00, 0x40, 0x00, 0x40.
- L writes 0x11223344 to 0x20 with c_be/l_be = 4'b1111 and l_lock = 1 for 3 cycles while c_req = 1 -> l_gnt high 3 cycles, c_gnt = 0 throughout, mem_we = 1; on the 4th cycle (l_lock = 0, l_req = 0) c_gnt = 1.
- L read granted, reset asserted on the following cycle -> l_rvalid stays 0; all outputs return to 0; the next conflict grants C.
- Single L request with no conflict repeated 5 cycles -> l_gnt = 1 every cycle; no C starvation check needed; last_served = L.
- With DMEM_ARB_CORE_PRIO_EN defined, both req and l_lock = 1 for 3 cycles -> c_gnt = 1 all 3 cycles, l_gnt = 0.
